// File: rtl/weight_loader_pkg.sv
// ----------------------------------------------------------------------------
// weight_loader_pkg : shared defaults and FSM state encodings for the loader.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package weight_loader_pkg;

  localparam int c_def_data_width   = 32;
  localparam int c_def_input_nodes  = 100;
  localparam int c_def_output_nodes = 32;
  localparam int c_addr_width       = 11;

  typedef logic [1:0] state_t;

  localparam state_t c_st_idle  = 2'd0;
  localparam state_t c_st_load  = 2'd1;
  localparam state_t c_st_write = 2'd2;
  localparam state_t c_st_done  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/weight_loader_if.sv
// ----------------------------------------------------------------------------
// weight_loader_if : weight input stream plus packed row-write bus.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface weight_loader_if
  import weight_loader_pkg::*;
#(
  parameter int DATA_WIDTH   = c_def_data_width,
  parameter int OUTPUT_NODES = c_def_output_nodes
);

  logic                             in_valid;
  logic [DATA_WIDTH-1:0]            in_data;
  logic                             in_ready;
  logic                             wr_en;
  logic [c_addr_width-1:0]          wr_addr;
  logic [DATA_WIDTH*OUTPUT_NODES-1:0] wr_row;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_row
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_row
  );

endinterface

`default_nettype wire

// File: rtl/weight_loader_row_packer.sv
// ----------------------------------------------------------------------------
// weight_loader_row_packer : column counter and slot writer for one weight row.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module weight_loader_row_packer #(
  parameter int DATA_WIDTH   = 32,
  parameter int OUTPUT_NODES = 32
) (
  input  wire logic                               clk,
  input  wire logic                               reset,
  input  wire logic                               i_clear,
  input  wire logic                               i_accept,
  input  wire logic [DATA_WIDTH-1:0]              i_data,
  output logic                                    o_last,
  output logic [DATA_WIDTH*OUTPUT_NODES-1:0]      o_row
);

  localparam int c_col_w = (OUTPUT_NODES > 1) ? $clog2(OUTPUT_NODES) : 1;

  logic [c_col_w-1:0]                 r_col;
  logic [DATA_WIDTH*OUTPUT_NODES-1:0] r_row;

  assign o_last = (r_col == c_col_w'(OUTPUT_NODES - 1));
  assign o_row  = r_row;

  // Column 0 lands in the top slot so the row reads out MSB-first.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_accept) begin
      for (int k = 0; k < OUTPUT_NODES; k++) begin
        if (r_col == c_col_w'(OUTPUT_NODES - 1 - k)) begin
          r_row[k*DATA_WIDTH +: DATA_WIDTH] <= i_data;
        end
      end
      r_col <= o_last ? '0 : r_col + c_col_w'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/weight_loader.sv
// ----------------------------------------------------------------------------
// weight_loader : streams weight words into packed rows and writes them out.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int DATA_WIDTH   = c_def_data_width,
  parameter int INPUT_NODES  = c_def_input_nodes,
  parameter int OUTPUT_NODES = c_def_output_nodes
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        start,
  input  wire logic        abort,
  weight_loader_if.slave   bus,
  output logic             busy,
  output logic             done
);

  state_t                  r_state;
  state_t                  w_next;
  logic                    w_in_ready;
  logic                    w_busy;
  logic                    w_accept;
  logic                    w_last_col;
  logic                    w_last_row;
  logic                    w_clear;
  logic [c_addr_width-1:0] r_row;
  logic [c_addr_width-1:0] r_wr_addr;
  logic                    r_wr_en;
  logic                    r_done;

  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_last_row = (r_row == c_addr_width'(INPUT_NODES - 1));
  assign w_clear    = abort || ((r_state == c_st_idle) && start);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle:  if (start) w_next = c_st_load;
      c_st_load:  if (w_accept && w_last_col) w_next = c_st_write;
      c_st_write: w_next = w_last_row ? c_st_done : c_st_load;
      c_st_done:  w_next = c_st_idle;
      default:    w_next = c_st_idle;
    endcase
    if (abort) begin
      w_next = c_st_idle;
    end
  end

  always_comb begin
    w_in_ready = (r_state == c_st_load);
    w_busy     = (r_state == c_st_load) || (r_state == c_st_write);
  end

  // Strobes are decoded from the next state so they line up with WRITE/DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row     <= '0;
      r_wr_addr <= '0;
      r_wr_en   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_wr_en <= (w_next == c_st_write);
      r_done  <= (w_next == c_st_done);
      if (w_next == c_st_write) begin
        r_wr_addr <= r_row;
      end
      if (abort || (r_state == c_st_idle) || (r_state == c_st_done)) begin
        r_row <= '0;
      end else if ((r_state == c_st_write) && !w_last_row) begin
        r_row <= r_row + c_addr_width'(1);
      end
    end
  end

  weight_loader_row_packer #(
    .DATA_WIDTH   (DATA_WIDTH),
    .OUTPUT_NODES (OUTPUT_NODES)
  ) u_packer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_accept (w_accept && !abort),
    .i_data   (bus.in_data),
    .o_last   (w_last_col),
    .o_row    (bus.wr_row)
  );

  assign bus.in_ready = w_in_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign busy         = w_busy;
  assign done         = r_done;

endmodule

`default_nettype wire

// File: tb/tb_weight_loader.sv
// ----------------------------------------------------------------------------
// tb_weight_loader : directed scoreboard bench, 3 rows of 4 words each.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_weight_loader;

  localparam int c_dw = 32;
  localparam int c_in = 3;
  localparam int c_on = 4;

  typedef struct {
    bit           is_done;
    logic [10:0]  addr;
    logic [127:0] row;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset, start, abort, busy, done;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  logic [127:0] exp_rows [3] = '{
    128'h00000001_00000002_00000003_00000004,
    128'h00000005_00000006_00000007_00000008,
    128'h00000009_0000000A_0000000B_0000000C
  };

  weight_loader_if #(.DATA_WIDTH(c_dw), .OUTPUT_NODES(c_on)) bus ();

  weight_loader #(
    .DATA_WIDTH   (c_dw),
    .INPUT_NODES  (c_in),
    .OUTPUT_NODES (c_on)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .abort (abort),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every row write or done pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (bus.wr_en === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL wr_unexpected: got write addr %0d at cycle %0d, required none", bus.wr_addr, cyc);
      end else begin
        e = sb.pop_front();
        if (e.is_done || bus.wr_addr !== e.addr || bus.wr_row !== e.row || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL row_write: got addr %0d row %h cyc %0d, required done=%0b addr %0d row %h cyc %0d",
                   bus.wr_addr, bus.wr_row, cyc, e.is_done, e.addr, e.row, e.cyc);
        end
      end
    end
    if (done === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL done_unexpected: got done at cycle %0d, required none", cyc);
      end else begin
        e = sb.pop_front();
        if (!e.is_done || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL done_pulse: got done at cyc %0d, required done=%0b at cyc %0d",
                   cyc, e.is_done, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, 128'(bus.in_ready), 128'd0);
    check({tag, "_wr_en"},    128'(bus.wr_en),    128'd0);
    check({tag, "_wr_addr"},  128'(bus.wr_addr),  128'd0);
    check({tag, "_wr_row"},   bus.wr_row,         128'd0);
    check({tag, "_busy"},     128'(busy),         128'd0);
    check({tag, "_done"},     128'(done),         128'd0);
  endtask

  // Present one word and hold it until the handshake completes; k is the
  // cycle count seen on the negedge just before the accepting edge.
  task automatic send_word(input logic [31:0] d, output int k);
    bit ok = 1'b0;
    k = -1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        k  = cyc;
      end
      tick();
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got no in_ready for word %h, required in_ready within 40 cycles", d);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_row(input int r, input bit gap, input bit mid_start, output int k);
    for (int c = 0; c < c_on; c++) begin
      send_word(32'(c_on * r + c + 1), k);
      if (c == c_on - 1) sb.push_back('{1'b0, 11'(r), exp_rows[r], k + 1});
      if (gap) begin
        bus.in_valid = 1'b0;
        tick();
      end
      if (mid_start && c == 1) begin
        bus.in_valid = 1'b0;
        pulse_start();
        @(negedge clk);
        check("start_in_load_busy", 128'(busy), 128'd1);
        tick();
      end
    end
  endtask

  task automatic load_all(input bit gap, input bit mid_start);
    int k;
    pulse_start();
    for (int r = 0; r < c_in; r++) begin
      load_row(r, gap, mid_start && r == 0, k);
    end
    sb.push_back('{1'b1, 11'd0, 128'd0, k + 2});
    bus.in_valid = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (2) @(posedge clk);
    check_all_zero("reset");
    tick();
    reset = 1'b0;
    tick();

    // Back-to-back stream, then the same stream with a gap after every word.
    load_all(1'b0, 1'b0);
    load_all(1'b1, 1'b0);

    // Stray valid data in IDLE, and a start pulse in the middle of LOAD.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000DEAD;
    @(negedge clk);
    check("idle_in_ready", 128'(bus.in_ready), 128'd0);
    check("idle_busy",     128'(busy),         128'd0);
    repeat (2) tick();
    bus.in_valid = 1'b0;
    load_all(1'b0, 1'b1);

    // Abort two words into row 1, then restart from row 0.
    pulse_start();
    load_row(0, 1'b0, 1'b0, k);
    send_word(32'h5, k);
    send_word(32'h6, k);
    bus.in_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy",     128'(busy),         128'd0);
    check("abort_in_ready", 128'(bus.in_ready), 128'd0);
    repeat (8) tick();
    load_all(1'b0, 1'b0);

    // Abort coincident with the last word of row 0.
    pulse_start();
    send_word(32'h1, k);
    send_word(32'h2, k);
    send_word(32'h3, k);
    bus.in_data = 32'h4;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("abort_last_wr_en", 128'(bus.wr_en), 128'd0);
    check("abort_last_busy",  128'(busy),      128'd0);
    repeat (6) tick();

    // Reset on the WRITE cycle of row 0.
    pulse_start();
    load_row(0, 1'b0, 1'b0, k);
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_all_zero("reset_in_write");
    tick();
    reset = 1'b0;
    repeat (10) tick();

    check("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
